dcache_controller: RTL

Direct-mapped, write-back, write-allocate data cache placed between the CPU's MEM stage and the 256-bit-line `Data_Memory`. Serves 32-bit loads and stores from 32 internal lines of 256 bits, stalls the pipeline on a miss, and runs the memory enable/ack handshake to write back dirty victims and refill lines.

---
 rtl/dcache_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// between the CPU MEM stage and a line-wide data memory.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | serve hits; a miss moves to MISS
// MISS        | pick write-back (dirty victim) or refill, raise mem enable
// WRITEBACK   | victim line on the bus, wait for ack
// REFILL      | read request for the new line, wait for ack
// REFILL_DONE | line installed; the held request hits on return to IDLE
module dcache_controller #(
   parameter int LINES  = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [31:0]       mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
);
   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int TAG_W = 32 - IDX_W - OFF_W;
   localparam int WRD_W = OFF_W - 2;

   typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE} state_t;

   state_t              state_q;
   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    dirty_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [LINE_W-1:0]   data_q [LINES];
   logic                mem_enable_q;
   logic                mem_write_q;
   logic [31:0]         mem_addr_q;
   logic [LINE_W-1:0]   mem_data_q;

   logic [TAG_W-1:0]    p1_tag;
   logic [IDX_W-1:0]    p1_idx;
   logic [WRD_W-1:0]    p1_word;
   logic [WRD_W+4:0]    bit_off;
   logic [LINE_W-1:0]   cur_line;
   logic [TAG_W-1:0]    cur_tag;
   logic [31:0]         fill_addr;
   logic [31:0]         victim_addr;
   logic                req;
   logic                hit;
   logic                wr_hit;
   logic                addr_unused;

   assign p1_tag      = p1_addr_i[31 -: TAG_W];
   assign p1_idx      = p1_addr_i[OFF_W +: IDX_W];
   assign p1_word     = p1_addr_i[2 +: WRD_W];
   assign addr_unused = ^p1_addr_i[1:0];
   assign bit_off     = {p1_word, 5'b0};
   assign cur_line    = data_q[p1_idx];
   assign cur_tag     = tag_q[p1_idx];
   assign fill_addr   = {p1_tag, p1_idx, {OFF_W{1'b0}}};
   assign victim_addr = {cur_tag, p1_idx, {OFF_W{1'b0}}};

   assign req    = p1_MemRead_i | p1_MemWrite_i;
   assign hit    = req && valid_q[p1_idx] && (cur_tag == p1_tag);
   assign wr_hit = (state_q == IDLE) && hit && p1_MemWrite_i;

   // The refilled line already hits in REFILL_DONE, so the stall is also
   // held for every non-IDLE state to keep the pipeline frozen until IDLE.
   assign p1_stall_o = req && (!hit || (state_q != IDLE));
   assign p1_data_o  = p1_MemRead_i ? cur_line[bit_off +: 32] : 32'd0;

   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   // Miss sequencing, valid/dirty bookkeeping and registered memory handshake
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && !hit) begin
                  state_q <= MISS;
               end else if (wr_hit) begin
                  dirty_q[p1_idx] <= 1'b1;
               end
            end
            MISS: begin
               mem_enable_q <= 1'b1;
               if (valid_q[p1_idx] && dirty_q[p1_idx]) begin
                  state_q     <= WRITEBACK;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= victim_addr;
                  mem_data_q  <= cur_line;
               end else begin
                  state_q     <= REFILL;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= fill_addr;
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  dirty_q[p1_idx] <= 1'b0;
                  state_q         <= REFILL;
                  mem_write_q     <= 1'b0;
                  mem_addr_q      <= fill_addr;
               end
            end
            REFILL: begin
               if (mem_ack_i) begin
                  valid_q[p1_idx] <= 1'b1;
                  dirty_q[p1_idx] <= 1'b0;
                  mem_enable_q    <= 1'b0;
                  state_q         <= REFILL_DONE;
               end
            end
            REFILL_DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Line storage: install refill data on ack, merge store word on a hit
   always_ff @(posedge clk_i) begin
      if ((state_q == REFILL) && mem_ack_i) begin
         data_q[p1_idx] <= mem_data_i;
         tag_q[p1_idx]  <= p1_tag;
      end else if (wr_hit) begin
         data_q[p1_idx][bit_off +: 32] <= p1_data_i;
      end
   end

endmodule
